// File: rtl/score_draw_ctrl.sv
// Score renderer: latches a binary score, converts it to BCD by sequential double-dabble,
// then drives the glyph drawer digit by digit, most significant first. Optional macro: LEADING_ZERO_BLANK_EN.
module score_draw_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int SCORE_W     = 14,
   parameter int DIGIT_PITCH = 14
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [SCORE_W-1:0] score,
   input  logic [7:0]         x_base,
   input  logic [7:0]         y_base,
   output logic               busy,
   output logic               done,
   output logic [3:0]         digit_select,
   output logic [7:0]         digit_x,
   output logic [7:0]         digit_y,
   output logic               digit_reset,
   output logic               digit_enable,
   input  logic               digit_end,
   output logic               plot
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic longint unsigned pow10(input int n);
      longint unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam longint unsigned SAT_LIMIT = pow10(NUM_DIGITS);

   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_LOAD, S_DRAW, S_NEXT, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] bin_q, bin_d;
   logic               sat_q, sat_d;
   logic [7:0]         xb_q, xb_d, yb_q, yb_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [3:0]         sel_q, sel_d;
   logic [7:0]         dx_q, dx_d, dy_q, dy_d;
   logic               drst_q, drst_d, den_q, den_d;

   logic [BCD_W-1:0]   bcd_adj, bcd_next;
   logic [IDX_W-1:0]   idx_first;

   // NOTE: every variable gets its default at the top of always_comb so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      sat_d     = sat_q;
      xb_d      = xb_q;
      yb_d      = yb_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = done_q;
      sel_d     = sel_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      drst_d    = drst_q;
      den_d     = den_q;
      bcd_adj   = bcd_q;
      bcd_next  = bcd_q;
      idx_first = IDX_W'(NUM_DIGITS - 1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d   = score;
               sat_d   = (64'(score) >= SAT_LIMIT);
               xb_d    = x_base;
               yb_d    = y_base;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            for (int i = 0; i < NUM_DIGITS; i++)
               if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            bcd_next = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
            bin_d    = bin_q << 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SCORE_W - 1)) begin
               if (sat_q) bcd_next = {NUM_DIGITS{4'h9}};
`ifdef LEADING_ZERO_BLANK_EN
               // Start at the highest nonzero digit; digit 0 is always drawn.
               idx_first = '0;
               for (int i = 0; i < NUM_DIGITS; i++)
                  if (bcd_next[i*4 +: 4] != 4'd0) idx_first = IDX_W'(i);
`endif
               idx_d   = idx_first;
               state_d = S_LOAD;
            end
            bcd_d = bcd_next;
         end
         S_LOAD: begin
            drst_d  = 1'b0;
            den_d   = 1'b1;
            state_d = S_DRAW;
         end
         S_DRAW: begin
            if (digit_end) begin
               drst_d  = 1'b1;
               den_d   = 1'b0;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == '0) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q - 1'b1;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Digit outputs are loaded only on entry to LOAD and then held until the next LOAD.
      if (state_d == S_LOAD) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            if (idx_d == IDX_W'(i)) sel_d = bcd_d[i*4 +: 4];
         dx_d = xb_d + 8'((NUM_DIGITS - 1 - int'(idx_d)) * DIGIT_PITCH);
         dy_d = yb_d;
      end
   end

   // NOTE: all state, including the BCD and shift registers, is reset so a mid-draw reset leaves nothing stale.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         sat_q   <= 1'b0;
         xb_q    <= '0;
         yb_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sel_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         drst_q  <= 1'b1;
         den_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         bin_q   <= bin_d;
         sat_q   <= sat_d;
         xb_q    <= xb_d;
         yb_q    <= yb_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sel_q   <= sel_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         drst_q  <= drst_d;
         den_q   <= den_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign digit_select = sel_q;
   assign digit_x      = dx_q;
   assign digit_y      = dy_q;
   assign digit_reset  = drst_q;
   assign digit_enable = den_q;
   assign plot         = den_q & ~digit_end;

endmodule

// File: tb/tb_score_draw_ctrl.sv
// Directed bench for score_draw_ctrl with a simple glyph-drawer model; honours LEADING_ZERO_BLANK_EN.
module tb_score_draw_ctrl;

   localparam int SCORE_W = 14;
   localparam int G       = 3;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic               start = 1'b0;
   logic [SCORE_W-1:0] score = '0;
   logic [7:0]         x_base = '0, y_base = '0;
   logic               busy, done, digit_reset, digit_enable, digit_end, plot;
   logic [3:0]         digit_select;
   logic [7:0]         digit_x, digit_y;

   int n_checks = 0;
   int n_fail   = 0;

   score_draw_ctrl dut (
      .clk(clk), .resetn(resetn), .start(start), .score(score),
      .x_base(x_base), .y_base(y_base), .busy(busy), .done(done),
      .digit_select(digit_select), .digit_x(digit_x), .digit_y(digit_y),
      .digit_reset(digit_reset), .digit_enable(digit_enable),
      .digit_end(digit_end), .plot(plot)
   );

   always #5 clk = ~clk;

   // Glyph drawer model: G steps, then a sticky end flag until reset.
   int g_cnt = 0;
   always @(posedge clk) begin
      if (digit_reset) g_cnt <= 0;
      else if (digit_enable && g_cnt != G) g_cnt <= g_cnt + 1;
   end
   assign digit_end = (g_cnt == G);

   // Capture each digit at the start of its DRAW phase.
   int   cap_sel[$], cap_x[$], cap_y[$];
   int   done_cnt = 0, plot_cnt = 0;
   logic en_prev = 1'b0;
   always @(negedge clk) begin
      if (digit_enable && !en_prev) begin
         cap_sel.push_back(int'(digit_select));
         cap_x.push_back(int'(digit_x));
         cap_y.push_back(int'(digit_y));
      end
      if (done) done_cnt <= done_cnt + 1;
      if (plot) plot_cnt <= plot_cnt + 1;
      en_prev <= digit_enable;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_case(input string tag, input logic [SCORE_W-1:0] s,
                           input logic [7:0] xb, input logic [7:0] yb, input int n,
                           input int es[4], input int ex[4], input bit inject);
      int base, dbase, pbase, lat;
      bit injected;
      injected = 1'b0;
      base  = cap_sel.size();
      dbase = done_cnt;
      pbase = plot_cnt;
      @(negedge clk);
      score = s; x_base = xb; y_base = yb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ":busy_rise"}, int'(busy), 1);
      lat = 0;
      while (!digit_enable && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ":first_draw_latency"}, lat, SCORE_W + 1);
      for (int c = 0; c < 400 && done_cnt == dbase; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (inject && !injected && (cap_sel.size() - base) == 2 && digit_enable) begin
            score = 14'd1111; x_base = 8'd0; y_base = 8'd0;
            start = 1'b1;
            injected = 1'b1;
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      if (inject) check({tag, ":start_injected"}, int'(injected), 1);
      check({tag, ":done_pulses"}, done_cnt - dbase, 1);
      check({tag, ":busy_after"}, int'(busy), 0);
      check({tag, ":done_after"}, int'(done), 0);
      check({tag, ":digits_drawn"}, cap_sel.size() - base, n);
      for (int i = 0; i < n && (base + i) < cap_sel.size(); i++) begin
         check($sformatf("%s:sel%0d", tag, i), cap_sel[base+i], es[i]);
         check($sformatf("%s:x%0d", tag, i), cap_x[base+i], ex[i]);
         check($sformatf("%s:y%0d", tag, i), cap_y[base+i], int'(yb));
      end
      check({tag, ":plot_cycles"}, plot_cnt - pbase, G * n);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":busy"}, int'(busy), 0);
      check({tag, ":done"}, int'(done), 0);
      check({tag, ":sel"}, int'(digit_select), 0);
      check({tag, ":x"}, int'(digit_x), 0);
      check({tag, ":y"}, int'(digit_y), 0);
      check({tag, ":dreset"}, int'(digit_reset), 1);
      check({tag, ":denable"}, int'(digit_enable), 0);
      check({tag, ":plot"}, int'(plot), 0);
   endtask

   initial begin
      int w;
      #12;
      check_reset_outputs("por");
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      run_case("s1234", 14'd1234, 8'd10, 8'd5, 4, '{1, 2, 3, 4}, '{10, 24, 38, 52}, 1'b0);
      run_case("s10000", 14'd10000, 8'd0, 8'd0, 4, '{9, 9, 9, 9}, '{0, 14, 28, 42}, 1'b0);
      run_case("s16383", 14'd16383, 8'd1, 8'd2, 4, '{9, 9, 9, 9}, '{1, 15, 29, 43}, 1'b0);
      run_case("s9999", 14'd9999, 8'd3, 8'd7, 4, '{9, 9, 9, 9}, '{3, 17, 31, 45}, 1'b0);
      run_case("wrap5678", 14'd5678, 8'd240, 8'd100, 4, '{5, 6, 7, 8}, '{240, 254, 12, 26}, 1'b0);
      run_case("inject9021", 14'd9021, 8'd20, 8'd30, 4, '{9, 0, 2, 1}, '{20, 34, 48, 62}, 1'b1);

      // Asynchronous reset in the middle of a DRAW phase.
      @(negedge clk);
      score = 14'd3333; x_base = 8'd60; y_base = 8'd61; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!digit_enable && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("midreset:reached_draw", int'(digit_enable), 1);
      #2 resetn = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

`ifdef LEADING_ZERO_BLANK_EN
      run_case("s42", 14'd42, 8'd0, 8'd9, 2, '{4, 2, 0, 0}, '{28, 42, 0, 0}, 1'b0);
      run_case("blank7", 14'd7, 8'd50, 8'd11, 1, '{7, 0, 0, 0}, '{92, 0, 0, 0}, 1'b0);
      run_case("blank0", 14'd0, 8'd50, 8'd12, 1, '{0, 0, 0, 0}, '{92, 0, 0, 0}, 1'b0);
      run_case("blank1005", 14'd1005, 8'd4, 8'd13, 4, '{1, 0, 0, 5}, '{4, 18, 32, 46}, 1'b0);
`else
      run_case("s42", 14'd42, 8'd0, 8'd9, 4, '{0, 0, 4, 2}, '{0, 14, 28, 42}, 1'b0);
      run_case("s7", 14'd7, 8'd50, 8'd11, 4, '{0, 0, 0, 7}, '{50, 64, 78, 92}, 1'b0);
      run_case("s0", 14'd0, 8'd50, 8'd12, 4, '{0, 0, 0, 0}, '{50, 64, 78, 92}, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
